// File: rtl/satatb_8b10bw_if.sv
// Word-level handshake bundle between the 32-bit word source, the
// 8b/10b word encoder and the downstream serializer model.
interface satatb_8b10bw_if;
  logic        S_VALID;
  logic        S_READY;
  logic        S_CTRL;
  logic [31:0] S_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic        M_ILLEGAL;
  logic [39:0] M_DATA;

  // Encoder side: consumes S_*, produces M_*.
  modport slave (
    input  S_VALID, S_CTRL, S_DATA, M_READY,
    output S_READY, M_VALID, M_ILLEGAL, M_DATA
  );

  // Bench / neighbour side: drives S_*, consumes M_*.
  modport master (
    output S_VALID, S_CTRL, S_DATA, M_READY,
    input  S_READY, M_VALID, M_ILLEGAL, M_DATA
  );
endinterface

// File: rtl/satatb_8b10bw.sv
// 32-bit to 40-bit 8b/10b word encoder for the SATA bench serializer.
// Four code groups per word, byte 0 in M_DATA[39:30], running disparity
// chained byte to byte and word to word. Only K28.3 / K28.7 are encodable
// in byte 0; any other control request is sent as data and flagged.
module satatb_8b10bw #(
  parameter logic INITIAL_RD     = 1'b0,
  parameter int   OPT_REGISTERED = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  satatb_8b10bw_if.slave bus,
  output logic           o_rd
);

  // 5b/6b codes (abcdei) as sent at RD-; RD+ form is the complement when
  // the code is unbalanced, and for D.7.
  localparam logic [5:0] ENC6_NEG [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  // 3b/4b codes (fghj) as sent at RD-; complemented at RD+ when
  // unbalanced, and for .3 and .7.
  localparam logic [3:0] ENC4_NEG [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [5:0] K28_NEG = 6'b001111;

  // Returns {rd_out, abcdei, fghj} for one byte at the given running disparity.
  function automatic logic [10:0] enc_byte(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       flip6;
    logic       flip4;
    logic       rd6;
    logic       alt;
    x     = b[4:0];
    y     = b[7:5];
    s6    = k ? K28_NEG : ENC6_NEG[x];
    flip6 = ($countones(s6) != 3);
    rd6   = rd ^ flip6;
    // Alternate .7 avoids a run of five equal bits across the sub-block seam.
    alt   = (y == 3'd7) &&
            (k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                  ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    s4    = alt ? 4'b0111 : ENC4_NEG[y];
    flip4 = ($countones(s4) != 2);
    // Polarity decisions use the unmodified RD- codes, so invert last.
    if (rd && (flip6 || (!k && x == 5'd7))) begin
      s6 = ~s6;
    end
    if (rd6 && (flip4 || y == 3'd3 || y == 3'd7)) begin
      s4 = ~s4;
    end
    return {rd6 ^ flip4, s6, s4};
  endfunction

  logic        rd_q, rd_d;
  logic        k0_c, illegal_c, accept;
  logic [10:0] enc0_c, enc1_c, enc2_c, enc3_c;
  logic [39:0] code_c;

  assign k0_c      = bus.S_CTRL && (bus.S_DATA[6:0] == 7'h7c);
  assign illegal_c = bus.S_CTRL && !k0_c;
  assign accept    = bus.S_VALID && bus.S_READY;

  // Encode the four bytes, each starting from the disparity left by the previous one.
  always_comb begin
    enc0_c = enc_byte(bus.S_DATA[7:0],   k0_c, rd_q);
    enc1_c = enc_byte(bus.S_DATA[15:8],  1'b0, enc0_c[10]);
    enc2_c = enc_byte(bus.S_DATA[23:16], 1'b0, enc1_c[10]);
    enc3_c = enc_byte(bus.S_DATA[31:24], 1'b0, enc2_c[10]);
    code_c = {enc0_c[9:0], enc1_c[9:0], enc2_c[9:0], enc3_c[9:0]};
  end

  // Running disparity advances only when a word is actually taken.
  always_comb begin
    rd_d = accept ? enc3_c[10] : rd_q;
  end

  // Running disparity register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_q <= INITIAL_RD;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign o_rd = rd_q;

  if (OPT_REGISTERED != 0) begin : g_reg
    logic        m_valid_q, m_valid_d;
    logic        m_illegal_q, m_illegal_d;
    logic [39:0] m_data_q, m_data_d;

    // Output slot: reload whenever free, zeroing the payload on idle slots.
    always_comb begin
      m_valid_d   = m_valid_q;
      m_illegal_d = m_illegal_q;
      m_data_d    = m_data_q;
      if (bus.S_READY) begin
        m_valid_d   = bus.S_VALID;
        m_illegal_d = bus.S_VALID && illegal_c;
        m_data_d    = bus.S_VALID ? code_c : '0;
      end
    end

    // Output slot registers; reset drops any word still held.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        m_valid_q   <= 1'b0;
        m_illegal_q <= 1'b0;
        m_data_q    <= '0;
      end else begin
        m_valid_q   <= m_valid_d;
        m_illegal_q <= m_illegal_d;
        m_data_q    <= m_data_d;
      end
    end

    assign bus.S_READY   = !m_valid_q || bus.M_READY;
    assign bus.M_VALID   = m_valid_q;
    assign bus.M_ILLEGAL = m_illegal_q;
    assign bus.M_DATA    = m_data_q;
  end else begin : g_comb
    assign bus.S_READY   = bus.M_READY;
    assign bus.M_VALID   = bus.S_VALID;
    assign bus.M_ILLEGAL = bus.S_VALID && illegal_c;
    assign bus.M_DATA    = bus.S_VALID ? code_c : '0;
  end

endmodule

// File: tb/tb_satatb_8b10bw.sv
// Bench for the 8b/10b word encoder: directed words from the test plan,
// a backpressure hold, a no-bubble burst, then random words with stalls
// and mid-stream resets, all checked by a queue-based scoreboard.
module tb_satatb_8b10bw;
  localparam logic INITIAL_RD = 1'b0;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic o_rd;

  satatb_8b10bw_if bus ();

  satatb_8b10bw #(
    .INITIAL_RD(INITIAL_RD),
    .OPT_REGISTERED(1)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus.slave),
    .o_rd   (o_rd)
  );

  always #5 i_clk = ~i_clk;

  // Textbook code tables, both disparity columns written out.
  localparam logic [5:0] SIX_M [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] SIX_P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] FOUR_M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] FOUR_P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

  typedef struct {
    logic        ctrl;
    logic [31:0] data;
    logic [39:0] code;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic model_rd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: returns {rd_after_word, 40-bit code}, byte 0 shifted in first.
  function automatic logic [40:0] model_word(input logic c, input logic [31:0] d, input logic rd_in);
    logic        r;
    logic [39:0] w;
    logic [7:0]  byt;
    logic [4:0]  x;
    logic [2:0]  y;
    logic [5:0]  six;
    logic [3:0]  four;
    logic        kk;
    logic        a7;
    r = rd_in;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      byt = 8'(d >> (8 * b));
      kk  = (b == 0) && c && (d[6:0] == 7'h7c);
      x   = byt[4:0];
      y   = byt[7:5];
      if (kk) six = r ? 6'b110000 : 6'b001111;
      else    six = r ? SIX_P[x] : SIX_M[x];
      if ($countones(six) != 3) r = ~r;
      a7 = (y == 3'd7) && (kk || (!r && (x inside {5'd17, 5'd18, 5'd20})) ||
                                 ( r && (x inside {5'd11, 5'd13, 5'd14})));
      if (a7) four = r ? 4'b1000 : 4'b0111;
      else    four = r ? FOUR_P[y] : FOUR_M[y];
      if ($countones(four) != 2) r = ~r;
      w = {w[29:0], six, four};
    end
    return {r, w};
  endfunction

  // Table-search decoder for one group: returns {k, byte}.
  function automatic logic [8:0] dec_group(input logic [9:0] g, output logic ok);
    logic [5:0] s;
    logic [3:0] f;
    logic       k;
    logic [4:0] x;
    logic [2:0] y;
    logic       fx;
    logic       fy;
    s = g[9:4]; f = g[3:0];
    k = 1'b0; x = '0; y = '0; fx = 1'b0; fy = 1'b0;
    if (s == 6'b001111 || s == 6'b110000) begin
      k = 1'b1; x = 5'd28; fx = 1'b1;
    end else begin
      for (int i = 0; i < 32; i++)
        if (SIX_M[5'(i)] == s || SIX_P[5'(i)] == s) begin x = 5'(i); fx = 1'b1; end
    end
    if (f == 4'b0111 || f == 4'b1000) begin
      y = 3'd7; fy = 1'b1;
    end else begin
      for (int j = 0; j < 8; j++)
        if (FOUR_M[3'(j)] == f || FOUR_P[3'(j)] == f) begin y = 3'(j); fy = 1'b1; end
    end
    ok = fx && fy;
    return {k, y, x};
  endfunction

  // Monitor: pops one expectation per delivered word.
  initial begin : monitor
    logic        mon_rd;
    exp_t        e;
    logic [31:0] dec;
    logic        dk, rt_ok, ok, dok;
    logic [8:0]  r9;
    logic [9:0]  g;
    int          n;
    mon_rd = INITIAL_RD;
    forever begin
      @(negedge i_clk); #1;
      if (i_reset) begin
        mon_rd = INITIAL_RD;
      end else if (bus.M_VALID && bus.M_READY) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got M_DATA=%h, expected no word pending", bus.M_DATA);
        end else begin
          e = sb.pop_front();
          chk("m_data", 64'(bus.M_DATA), 64'(e.code));
          chk("m_illegal", 64'(bus.M_ILLEGAL), 64'(e.ill));
          rt_ok = 1'b1; dec = '0; dk = 1'b0; dok = 1'b1;
          for (int b = 0; b < 4; b++) begin
            g  = 10'(bus.M_DATA >> (10 * (3 - b)));
            r9 = dec_group(g, ok);
            if (!ok) rt_ok = 1'b0;
            dec = {r9[7:0], dec[31:8]};
            if (b == 0) dk = r9[8];
            else if (r9[8]) rt_ok = 1'b0;
            n = $countones(g);
            if (n == 6) begin
              if (mon_rd) dok = 1'b0;
              mon_rd = 1'b1;
            end else if (n == 4) begin
              if (!mon_rd) dok = 1'b0;
              mon_rd = 1'b0;
            end else if (n != 5) begin
              dok = 1'b0;
            end
          end
          chk("roundtrip", 64'({rt_ok, dk, dec}),
              64'({1'b1, e.ctrl && (e.data[6:0] == 7'h7c), e.data}));
          chk("rd_sequence", 64'(dok), 64'(1));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Presents one word until taken; pushes the expectation at acceptance.
  task automatic drive(input logic c, input logic [31:0] d, input logic rnd,
                       input logic use_exp, input logic [39:0] ex, input logic exi,
                       output int waits);
    logic [40:0] m;
    exp_t        e;
    bus.S_VALID = 1'b1; bus.S_CTRL = c; bus.S_DATA = d;
    waits = 0;
    forever begin
      @(negedge i_clk);
      if (bus.S_READY) break;
      waits++;
      if (waits > 200) break;
      @(posedge i_clk); #1;
      if (rnd) bus.M_READY = ($urandom_range(0, 3) != 0);
    end
    if (waits > 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: got S_READY=0 for 200 cycles, expected acceptance");
    end else begin
      chk("o_rd", 64'(o_rd), 64'(model_rd));
      m      = model_word(c, d, model_rd);
      e.ctrl = c;
      e.data = d;
      e.code = use_exp ? ex : m[39:0];
      e.ill  = use_exp ? exi : (c && (d[6:0] != 7'h7c));
      sb.push_back(e);
      model_rd = m[40];
    end
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    bus.S_VALID = 1'b0; bus.S_CTRL = 1'b0; bus.S_DATA = '0;
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    bus.S_VALID = 1'b0;
    i_reset = 1'b1;
    sb.delete();
    model_rd = INITIAL_RD;
    repeat (2) begin @(posedge i_clk); #1; end
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_m_valid", 64'(bus.M_VALID), 64'(0));
    chk("rst_m_data", 64'(bus.M_DATA), 64'(0));
    chk("rst_m_illegal", 64'(bus.M_ILLEGAL), 64'(0));
    chk("rst_o_rd", 64'(o_rd), 64'(INITIAL_RD));
    @(posedge i_clk); #1;
  endtask

  initial begin : main
    int          w;
    logic        c;
    logic [31:0] d;
    logic [40:0] ma;
    logic [7:0]  b0;
    bus.S_VALID = 1'b0; bus.S_CTRL = 1'b0; bus.S_DATA = '0; bus.M_READY = 1'b1;
    model_rd = INITIAL_RD;
    @(posedge i_clk); #1;
    do_reset();

    // Four D0.0 at RD-, visible one cycle after acceptance.
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1, 40'h9D2749D274, 1'b0, w);
    bus.S_VALID = 1'b0;
    @(negedge i_clk);
    chk("latency_valid", 64'(bus.M_VALID), 64'(1));
    chk("latency_data", 64'(bus.M_DATA), 64'(40'h9D2749D274));
    @(posedge i_clk); #1;

    drive(1'b1, 32'hB5B5_B57C, 1'b0, 1'b1, {10'b0011110011, {3{10'b1010101010}}}, 1'b0, w);
    drive(1'b1, 32'h0000_007C, 1'b0, 1'b1, {10'b1100001100, {3{10'b1001110100}}}, 1'b0, w);
    drive(1'b1, 32'h0000_00BC, 1'b0, 1'b1, {10'b0011101010, {3{10'b1001110100}}}, 1'b1, w);
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1, 40'h9D2749D274, 1'b0, w);
    idle();

    // Back-to-back words with the sink always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, $urandom, 1'b0, 1'b0, '0, 1'b0, w);
      chk("no_bubble", 64'(w), 64'(0));
    end
    idle();

    // Sink stalls for five cycles with a second word waiting.
    bus.M_READY = 1'b0;
    d  = $urandom;
    ma = model_word(1'b0, d, model_rd);
    drive(1'b0, d, 1'b0, 1'b0, '0, 1'b0, w);
    d = $urandom;
    bus.S_VALID = 1'b1; bus.S_CTRL = 1'b0; bus.S_DATA = d;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("stall_s_ready", 64'(bus.S_READY), 64'(0));
      chk("stall_m_valid", 64'(bus.M_VALID), 64'(1));
      chk("stall_m_data", 64'(bus.M_DATA), 64'(ma[39:0]));
      chk("stall_o_rd", 64'(o_rd), 64'(ma[40]));
      @(posedge i_clk); #1;
    end
    bus.M_READY = 1'b1;
    drive(1'b0, d, 1'b0, 1'b0, '0, 1'b0, w);
    idle();

    // Random words, random stalls and idles, occasional reset mid-stream.
    for (int n = 0; n < 10000; n++) begin
      if (n % 2500 == 1234) do_reset();
      bus.M_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) idle();
      c = ($urandom_range(0, 5) == 0);
      d = $urandom;
      if (c) begin
        case ($urandom_range(0, 3))
          0:       b0 = 8'h7C;
          1:       b0 = 8'hFC;
          default: b0 = 8'($urandom);
        endcase
        d = {d[31:8], b0};
      end
      drive(c, d, 1'b1, 1'b0, '0, 1'b0, w);
    end

    bus.S_VALID = 1'b0;
    bus.M_READY = 1'b1;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    chk("drain_empty", 64'(sb.size()), 64'(0));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/satatb_8b10bw.md
Name: satatb_8b10bw

Overview:
- Bench-side 32-bit-to-40-bit 8b/10b encoder: converts one 32-bit word per beat into four 10-bit code groups.
- Tracks running disparity (RD) across bytes and across words.
- Feeds the serializer model of the SATA test bench; it is the transmit counterpart of the bench's 40-bit 10b/8b word decoder, and its output must round-trip through that decoder bit-exactly.

Parameters:
- INITIAL_RD, 1'b0: RD after reset; 0 = RD-, 1 = RD+.
- OPT_REGISTERED, 1: 1 = output registered (one-cycle latency); 0 = combinational output path, RD register still clocked.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset
- S_VALID  input  1  input word valid
- S_READY  output  1  input accepted when S_VALID && S_READY
- S_CTRL  input  1  byte 0 is a K-character
- S_DATA  input  32  word; S_DATA[7:0] is the first byte transmitted
- M_VALID  output  1  encoded word valid
- M_READY  input  1  downstream accepts
- M_ILLEGAL  output  1  requested K code not encodable; qualified by M_VALID
- M_DATA  output  40  code groups; M_DATA[39] is transmitted first
- o_rd  output  1  current running disparity (1 = RD+)

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk. On reset: M_VALID=0, M_ILLEGAL=0, M_DATA=0, o_rd=INITIAL_RD. Reset mid-stream discards any held output word.
- Byte mapping:
  - Byte k = S_DATA[8k+7:8k] encodes into M_DATA[39-10k:30-10k].
  - Within each group, code bit a is the MSB and j is the LSB (order abcdei fghj).
- Encoding: standard 5b/6b + 3b/4b tables.
  - The sub-block disparity rule applies: a non-neutral 6b sub-block flips RD before the 4b sub-block is chosen.
  - D.x.7 uses the alternate A7 encoding (0111/1000) when x is 17/18/20 with RD- or x is 11/13/14 with RD+.
- RD chaining: byte 0 uses RD register; byte k uses RD out of byte k-1; RD register loads RD out of byte 3 on acceptance only.
- Control:
  - When S_CTRL=1 and S_DATA[6:0]==7'h7c, byte 0 encodes as K28.3 (0x7C) or K28.7 (0xFC).
  - When S_CTRL=1 with any other byte 0 value: byte 0 encodes as data D.x.y, M_ILLEGAL=1 for that word.
  - Bytes 1-3 are always data.
- Handshake:
  - S_READY = !M_VALID || M_READY.
  - OPT_REGISTERED=1: on S_READY, M_VALID<=S_VALID and the outputs load. When S_VALID=0 and S_READY, M_DATA/M_ILLEGAL load 0. Output is held stable while M_VALID && !M_READY.
  - OPT_REGISTERED=0: M_VALID=S_VALID and outputs combinational; S_READY=M_READY.
- RD update:
  - occurs only on S_VALID && S_READY;
  - never changes during stall or idle;
  - is unaffected by M_ILLEGAL.
- Throughput: one word per clock with M_READY held high; no bubbles.

Test Plan:
- Reset, then word 32'h00000000, CTRL=0, RD- -> M_DATA=40'h9D2749D274 (four D0.0 = 1001110100), M_ILLEGAL=0, o_rd=0 after acceptance; output one cycle after acceptance when OPT_REGISTERED=1.
- CTRL=1, S_DATA=32'hB5B5B57C, RD- -> M_DATA={10'b0011110011, 3{10'b1010101010}}, o_rd=1 afterward.
- Next word, CTRL=1, S_DATA=32'h0000007C at RD+ -> byte0=10'b1100001100, RD flips to -; bytes 1-3 use RD- D0.0 codes. Decoding through the 10b/8b word decoder returns CTRL=1, DATA=32'h0000007C.
- CTRL=1, S_DATA=32'h000000BC -> M_ILLEGAL=1; byte 0 encoded as D28.5; next legal word -> M_ILLEGAL=0.
- Backpressure: M_READY=0 for 5 cycles with S_VALID=1 -> M_DATA, M_VALID and o_rd stable; S_READY=0; word sent exactly once when M_READY rises.
- Random 10k words with random stalls and mid-stream reset -> round-trip through the decoder matches the input. Every 10-bit group has disparity 0 or ±2 consistent with RD, and the RD sequence alternates correctly. After reset, o_rd=INITIAL_RD.
